// File: rtl/dmem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | dmem_arbiter: shares a single-port data memory between the core port and    |
// | the loader port. Round-robin arbitration with a bounded loader burst lock.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  // core load/store port
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  // loader/debug port
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_t;

  port_t         last;
  logic          lock_q;
  logic [CW-1:0] lock_cnt;
  logic          resp_c;
  logic          resp_l;
  logic          grant_c;
  logic          grant_l;

  // Grants depend only on registered state and current requests; reset masks everything.
  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    if (!rst) begin
      if (lock_q) begin
        grant_l = ld_req;
      end else if (core_req && ld_req) begin
        if (last == PORT_L) grant_c = 1'b1;
        else                grant_l = 1'b1;
      end else begin
        grant_c = core_req;
        grant_l = ld_req;
      end
    end
  end

  assign core_gnt   = grant_c;
  assign ld_gnt     = grant_l;
  assign core_stall = core_req & ~grant_c;
  assign mem_en     = grant_c | grant_l;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_c) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (grant_l) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign core_rvalid = resp_c & ~rst;
  assign ld_rvalid   = resp_l & ~rst;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ld_rdata    = ld_rvalid   ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= PORT_L;
      lock_q   <= 1'b0;
      lock_cnt <= '0;
      resp_c   <= 1'b0;
      resp_l   <= 1'b0;
    end else begin
      resp_c <= grant_c & ~core_we;
      resp_l <= grant_l & ~ld_we;

      if (grant_c)      last <= PORT_C;
      else if (grant_l) last <= PORT_L;

      if (lock_q) begin
        // An expired burst hands the next tie to the core even if the loader still locks.
        if (lock_cnt == CNT_LAST) begin
          lock_q   <= 1'b0;
          lock_cnt <= '0;
          last     <= PORT_L;
        end else if (!ld_req) begin
          lock_q   <= 1'b0;
          lock_cnt <= '0;
        end else begin
          lock_q   <= ld_lock;
          lock_cnt <= ld_lock ? lock_cnt + CW'(1) : '0;
        end
      end else begin
        lock_q   <= grant_l & ld_lock;
        lock_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_dmem_arbiter: directed and randomized checks of dmem_arbiter.            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: "who owned last", a lock flag and a remaining-cycle budget.
  logic m_last_l   = 1'b1;
  logic m_locked   = 1'b0;
  int   m_budget   = 0;
  logic m_resp_c   = 1'b0;
  logic m_resp_l   = 1'b0;
  logic          e_gc, e_gl, e_en, e_we, e_cv, e_lv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_crd, e_lrd;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    e_gc = 1'b0;
    e_gl = 1'b0;
    if (!rst) begin
      if (m_locked)                e_gl = ld_req;
      else if (core_req && ld_req) begin
        e_gc = m_last_l;
        e_gl = !m_last_l;
      end else begin
        e_gc = core_req;
        e_gl = ld_req;
      end
    end
    e_en    = e_gc || e_gl;
    e_we    = e_gc ? core_we    : (e_gl ? ld_we    : 1'b0);
    e_addr  = e_gc ? core_addr  : (e_gl ? ld_addr  : '0);
    e_wdata = e_gc ? core_wdata : (e_gl ? ld_wdata : '0);
    e_cv    = !rst && m_resp_c;
    e_lv    = !rst && m_resp_l;
    e_crd   = e_cv ? mem_rdata : '0;
    e_lrd   = e_lv ? mem_rdata : '0;
  endtask

  task automatic model_update();
    if (rst) begin
      m_last_l = 1'b1;
      m_locked = 1'b0;
      m_budget = 0;
      m_resp_c = 1'b0;
      m_resp_l = 1'b0;
    end else begin
      m_resp_c = e_gc && !core_we;
      m_resp_l = e_gl && !ld_we;
      if (e_gc) m_last_l = 1'b0;
      if (e_gl) m_last_l = 1'b1;
      if (m_locked) begin
        m_budget--;
        if (m_budget == 0) begin
          m_locked = 1'b0;
          m_last_l = 1'b1;
        end else if (!ld_req) begin
          m_locked = 1'b0;
        end else begin
          m_locked = ld_lock;
        end
      end else if (e_gl && ld_lock) begin
        m_locked = 1'b1;
        m_budget = LOCK_MAX;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk1("core_gnt",    core_gnt,    e_gc);
    chk1("ld_gnt",      ld_gnt,      e_gl);
    chk1("core_stall",  core_stall,  core_req && !e_gc);
    chk1("mem_en",      mem_en,      e_en);
    chk1("mem_we",      mem_we,      e_we);
    chkw("mem_addr",    mem_addr,    e_addr);
    chkw("mem_wdata",   mem_wdata,   e_wdata);
    chk1("core_rvalid", core_rvalid, e_cv);
    chk1("ld_rvalid",   ld_rvalid,   e_lv);
    chkw("core_rdata",  core_rdata,  e_crd);
    chkw("ld_rdata",    ld_rdata,    e_lrd);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ld_req   = 1'b0; ld_we   = 1'b0; ld_lock   = 1'b0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    idle_inputs();
    sample();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_rdata = '0;
    idle_inputs();

    // Reset holds off a pending core load, then it is granted immediately.
    core_req = 1'b1; core_addr = 32'h10;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk1("t1_rst_gnt", core_gnt, 1'b0);
      chk1("t1_rst_rvalid", core_rvalid, 1'b0);
      advance();
    end
    rst = 1'b0;
    sample();
    chk1("t1_gnt", core_gnt, 1'b1);
    chk1("t1_stall", core_stall, 1'b0);
    chkw("t1_addr", mem_addr, 32'h10);
    advance();
    core_req = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    sample();
    chk1("t2_rvalid", core_rvalid, 1'b1);
    chkw("t2_rdata", core_rdata, 32'hDEADBEEF);
    chk1("t2_ld_rvalid", ld_rvalid, 1'b0);
    advance();

    // Both ports requesting: strict alternation starting with the core.
    reset_cycle();
    core_req = 1'b1; core_addr = 32'h100;
    ld_req   = 1'b1; ld_addr   = 32'h200; ld_we = 1'b1; ld_wdata = 32'h5555AAAA;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = $urandom;
      sample();
      chk1("t3_core_gnt", core_gnt, (i % 2) == 0);
      chk1("t3_stall", core_stall, (i % 2) == 1);
      advance();
    end

    // Locked burst: grant plus LOCK_MAX locked cycles, then the core.
    reset_cycle();
    core_req = 1'b1; core_addr = 32'h40;
    sample(); advance();
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 32'h80;
    for (int i = 0; i < LOCK_MAX + 2; i++) begin
      sample();
      chk1("t4_ld_gnt", ld_gnt, i <= LOCK_MAX);
      chk1("t4_core_gnt", core_gnt, i == LOCK_MAX + 1);
      advance();
    end

    // Loader drops its request while locked: core waits one cycle, then wins.
    reset_cycle();
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1;
    sample(); chk1("t5_ld_gnt0", ld_gnt, 1'b1); advance();
    core_req = 1'b1;
    sample(); chk1("t5_ld_gnt1", ld_gnt, 1'b1); chk1("t5_stall1", core_stall, 1'b1); advance();
    ld_req = 1'b0;
    sample(); chk1("t5_core_held", core_gnt, 1'b0); advance();
    sample(); chk1("t5_core_gnt", core_gnt, 1'b1); advance();

    // Reset right after a locked loader read drops the response and the lock.
    reset_cycle();
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b0; ld_addr = 32'hC0;
    sample(); chk1("t6_ld_gnt", ld_gnt, 1'b1); advance();
    rst = 1'b1; ld_req = 1'b0; mem_rdata = 32'h12345678;
    sample(); chk1("t6_ld_rvalid", ld_rvalid, 1'b0); chkw("t6_ld_rdata", ld_rdata, '0); advance();
    rst = 1'b0; core_req = 1'b1; ld_req = 1'b1;
    sample(); chk1("t6_core_gnt", core_gnt, 1'b1); chk1("t6_ld_gnt_after", ld_gnt, 1'b0); advance();

    // Randomized traffic obeying the hold-until-granted rule.
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      if (!(core_req && !e_gc)) begin
        core_req   = $urandom_range(0, 1) == 1;
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = $urandom;
        core_wdata = $urandom;
      end
      if (!(ld_req && !e_gl)) begin
        ld_req   = $urandom_range(0, 3) != 0;
        ld_we    = $urandom_range(0, 1) == 1;
        ld_addr  = $urandom;
        ld_wdata = $urandom;
      end
      ld_lock   = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 39) == 0;
      mem_rdata = $urandom;
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
